axi4_lite_slave_regs: RTL and testbench
=======================================

# axi4_lite_slave_regs

AXI4-Lite slave register file that terminates transactions issued by the team's AXI4-Lite master. It holds NUM_REGS data registers, accepts write address and write data independently and in either order, returns a write response, and serves single-beat reads. It sits directly downstream of the master on the same bus, with matching address/data widths and 1-bit responses.

## Interface
- ADDRESS, 2, address width (word index, no byte offset bits)
- DATA_WIDTH, 8, register/data width; multiple of 8, max 32
- NUM_REGS, 4, implemented registers; 1..2^ADDRESS

- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- S_AWADDR  in  ADDRESS  write address
- S_AWVALID  in  1  write address valid
- S_AWREADY  out  1  write address ready
- S_WDATA  in  DATA_WIDTH  write data
- S_WSTRB  in  4  byte-lane strobes
- S_WVALID  in  1  write data valid
- S_WREADY  out  1  write data ready
- S_BRESP  out  1  write response, 0=OKAY, 1=SLVERR
- S_BVALID  out  1  write response valid
- S_BREADY  in  1  write response ready
- S_ARADDR  in  ADDRESS  read address
- S_ARVALID  in  1  read address valid
- S_ARREADY  out  1  read address ready
- S_RDATA  out  DATA_WIDTH  read data
- S_RRESP  out  1  read response, 0=OKAY, 1=SLVERR
- S_RVALID  out  1  read data valid
- S_RREADY  in  1  read data ready

## Operation
- Reset: all registers 0, all outputs 0, both FSMs idle, address/data latches cleared.
- Write FSM: states WR_IDLE, WR_RESP.
  - WR_IDLE: S_AWREADY=1 while no address latched; S_WREADY=1 while no data latched. An AW handshake latches the address; a W handshake latches data and strobes. Either may arrive first; both may arrive in the same cycle.
  - When address and data are both latched (or complete at the same edge), commit at that edge and go to WR_RESP.
  - Commit: addr < NUM_REGS → byte i of reg[addr] updated iff S_WSTRB[i]=1 and i < DATA_WIDTH/8; strobes above the width are ignored; BRESP=0. addr >= NUM_REGS → no register change, BRESP=1.
  - WR_RESP: S_BVALID=1, S_AWREADY=S_WREADY=0, BRESP stable; on S_BVALID&&S_BREADY → WR_IDLE, latches cleared.
- Read FSM: states RD_IDLE, RD_DATA.
  - RD_IDLE: S_ARREADY=1. On an AR handshake, S_RDATA is loaded with reg[addr] (or 0 with RRESP=1 if addr >= NUM_REGS), and the FSM moves to RD_DATA.
  - RD_DATA: S_RVALID=1, S_ARREADY=0, RDATA/RRESP stable; on S_RREADY → RD_IDLE. S_RDATA returns to 0 when idle.
- Read and write paths are fully independent and may be active in the same cycle.
- Collision: when a write commit and an AR handshake to the same register fall on the same edge, the read returns the pre-write value.
- All ready outputs are forced to 0 while ARESET=1.

## Timing
- Write: the commit occurs at the edge where the second of AW/W completes (edge N). The register holds the new value and S_BVALID=1 from cycle N+1. Minimum one idle cycle of AW/W readiness between bursts: readies return one cycle after the B handshake.
- Read: AR handshake at edge N → S_RVALID and S_RDATA valid from cycle N+1. If S_RREADY is already high, RVALID stays high exactly one cycle. Next AR is accepted from the cycle after the R handshake.
- VALID outputs, once asserted, hold until the handshake and never drop early.
- Reset asserted mid-transaction: reset takes effect at the next edge. In-flight AW, W, B, and R are discarded, registers are cleared, and no response is issued.
- Sustained throughput: 1 write per 2 cycles and 1 read per 2 cycles with READY held high.

## Test plan
- Reset, then read reg 2 → RVALID after 1 cycle, RDATA=0x00, RRESP=0.
- Same-cycle AW=1/W=0xA5/WSTRB=4'b0001, BREADY=1 → BVALID the next cycle with BRESP=0; a subsequent read of 1 returns 0xA5.
- W before AW (W at cycle 3, AW at cycle 6), data 0x3C to reg 3 → commit at cycle 6 edge, BVALID at cycle 7; WREADY=0 during cycles 4–6.
- NUM_REGS=3, write 0xFF to addr 3 → BRESP=1 and no register changed; read addr 3 → RDATA=0, RRESP=1.
- WSTRB=4'b0000 to reg 0 (holding 0x11) → BRESP=0, reg 0 still 0x11. Same-edge write 0x77 and read of reg 0 → read returns 0x11; the next read returns 0x77.
- Assert ARESET while BVALID=1 and BREADY=0 → BVALID=0 after the next edge and all registers read back 0.

Source files
------------

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register file: NUM_REGS byte-strobed registers, independent
// write (AW/W in any order) and read channels, 1-bit OKAY/SLVERR responses.
module axi4_lite_slave_regs #(
  parameter int ADDRESS    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDRESS-1:0]    S_AWADDR,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_WDATA,
  input  logic [3:0]            S_WSTRB,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic                  S_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [ADDRESS-1:0]    S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic                  S_RRESP,
  output logic                  S_RVALID,
  input  logic                  S_RREADY
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned NREGS  = NUM_REGS;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_full, w_full;
  logic [ADDRESS-1:0]    aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [3:0]            w_strb_q;
  logic                  bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [ADDRESS-1:0]    c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [3:0]            c_strb;

  function automatic logic in_range(input logic [ADDRESS-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  // Write channel; the commit operand comes from the latch or, if it completes
  // on this same edge, straight from the bus.
  always_comb begin
    wr_next   = wr_state;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_BVALID  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        S_AWREADY = !ARESET && !aw_full;
        S_WREADY  = !ARESET && !w_full;
      end
      WR_RESP: S_BVALID = 1'b1;
      default: ;
    endcase
    aw_hs  = S_AWVALID && S_AWREADY;
    w_hs   = S_WVALID && S_WREADY;
    b_hs   = S_BVALID && S_BREADY;
    commit = (wr_state == WR_IDLE) && (aw_full || aw_hs) && (w_full || w_hs);
    c_addr = aw_full ? aw_addr_q : S_AWADDR;
    c_data = w_full ? w_data_q : S_WDATA;
    c_strb = w_full ? w_strb_q : S_WSTRB;
    if (commit) wr_next = WR_RESP;
    if (b_hs)   wr_next = WR_IDLE;
  end

  always_comb begin
    rd_next   = rd_state;
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b0;
    case (rd_state)
      RD_IDLE: S_ARREADY = !ARESET;
      RD_DATA: S_RVALID = 1'b1;
      default: ;
    endcase
    ar_hs = S_ARVALID && S_ARREADY;
    r_hs  = S_RVALID && S_RREADY;
    if (ar_hs) rd_next = RD_DATA;
    if (r_hs)  rd_next = RD_IDLE;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= 1'b0;
      rresp_q   <= 1'b0;
      rdata_q   <= '0;
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= S_AWADDR;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= S_WDATA;
        w_strb_q <= S_WSTRB;
      end
      if (commit) begin
        bresp_q <= !in_range(c_addr);
        if (in_range(c_addr))
          for (int unsigned i = 0; i < NBYTES; i++)
            if (c_strb[i]) regs[c_addr][i*8 +: 8] <= c_data[i*8 +: 8];
      end
      if (b_hs) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bresp_q <= 1'b0;
      end
      // Nonblocking update means a same-edge read sees the pre-commit value.
      if (ar_hs) begin
        rdata_q <= in_range(S_ARADDR) ? regs[S_ARADDR] : '0;
        rresp_q <= !in_range(S_ARADDR);
      end
      if (r_hs) begin
        rdata_q <= '0;
        rresp_q <= 1'b0;
      end
    end
  end

  assign S_BRESP = bresp_q;
  assign S_RDATA = rdata_q;
  assign S_RRESP = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench: instance 0 has 4 registers, instance 1 has 3 (for SLVERR paths).
module tb_axi4_lite_slave_regs;

  logic clk;
  logic arst;
  logic [1:0] awaddr [2];
  logic [1:0] araddr [2];
  logic [7:0] wdata  [2];
  logic [7:0] rdata  [2];
  logic [3:0] wstrb  [2];
  logic awvalid [2], awready [2], wvalid [2], wready [2];
  logic bresp [2], bvalid [2], bready [2];
  logic arvalid [2], arready [2], rresp [2], rvalid [2], rready [2];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.ADDRESS(2), .DATA_WIDTH(8), .NUM_REGS(4)) dut0 (
    .ACLK(clk), .ARESET(arst),
    .S_AWADDR(awaddr[0]), .S_AWVALID(awvalid[0]), .S_AWREADY(awready[0]),
    .S_WDATA(wdata[0]), .S_WSTRB(wstrb[0]), .S_WVALID(wvalid[0]), .S_WREADY(wready[0]),
    .S_BRESP(bresp[0]), .S_BVALID(bvalid[0]), .S_BREADY(bready[0]),
    .S_ARADDR(araddr[0]), .S_ARVALID(arvalid[0]), .S_ARREADY(arready[0]),
    .S_RDATA(rdata[0]), .S_RRESP(rresp[0]), .S_RVALID(rvalid[0]), .S_RREADY(rready[0])
  );

  axi4_lite_slave_regs #(.ADDRESS(2), .DATA_WIDTH(8), .NUM_REGS(3)) dut1 (
    .ACLK(clk), .ARESET(arst),
    .S_AWADDR(awaddr[1]), .S_AWVALID(awvalid[1]), .S_AWREADY(awready[1]),
    .S_WDATA(wdata[1]), .S_WSTRB(wstrb[1]), .S_WVALID(wvalid[1]), .S_WREADY(wready[1]),
    .S_BRESP(bresp[1]), .S_BVALID(bvalid[1]), .S_BREADY(bready[1]),
    .S_ARADDR(araddr[1]), .S_ARVALID(arvalid[1]), .S_ARREADY(arready[1]),
    .S_RDATA(rdata[1]), .S_RRESP(rresp[1]), .S_RVALID(rvalid[1]), .S_RREADY(rready[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int d, input logic [1:0] a, input logic [7:0] data,
                          input logic [3:0] strb, input logic exp_resp, input string tag);
    int  n;
    logic aw_done, w_done;
    awaddr[d] = a; wdata[d] = data; wstrb[d] = strb;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b1;
    n = 0;
    while (bvalid[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      aw_done = awvalid[d] && awready[d];
      w_done  = wvalid[d] && wready[d];
      step();
      if (aw_done) awvalid[d] = 1'b0;
      if (w_done)  wvalid[d] = 1'b0;
      n++;
    end
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    check({tag, "_bvalid"}, bvalid[d], 1'b1);
    check({tag, "_bresp"}, bresp[d], exp_resp);
    step();
    bready[d] = 1'b0;
    check({tag, "_bdone"}, bvalid[d], 1'b0);
  endtask

  task automatic do_read(input int d, input logic [1:0] a, input logic [7:0] exp,
                         input logic exp_resp, input string tag);
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b1;
    @(negedge clk);
    check({tag, "_arready"}, arready[d], 1'b1);
    step();
    arvalid[d] = 1'b0;
    check({tag, "_rvalid"}, rvalid[d], 1'b1);
    check({tag, "_rdata"}, rdata[d], exp);
    check({tag, "_rresp"}, rresp[d], exp_resp);
    step();
    rready[d] = 1'b0;
    check({tag, "_rvalid_drop"}, rvalid[d], 1'b0);
    check({tag, "_rdata_idle"}, rdata[d], 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      awaddr[d] = '0; araddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      awvalid[d] = 1'b0; wvalid[d] = 1'b0; bready[d] = 1'b0;
      arvalid[d] = 1'b0; rready[d] = 1'b0;
    end
    arst = 1'b1;
    repeat (3) step();
    check("rst_awready", awready[0], 1'b0);
    check("rst_wready", wready[0], 1'b0);
    check("rst_arready", arready[0], 1'b0);
    check("rst_bvalid", bvalid[0], 1'b0);
    check("rst_rvalid", rvalid[0], 1'b0);
    arst = 1'b0;
    step();
    check("idle_awready", awready[0], 1'b1);
    check("idle_wready", wready[0], 1'b1);
    check("idle_arready", arready[0], 1'b1);
    check("idle_rdata", rdata[0], 8'h00);

    do_read(0, 2'd2, 8'h00, 1'b0, "rd_rst_reg2");

    // AW and W in the same cycle
    awaddr[0] = 2'd1; wdata[0] = 8'hA5; wstrb[0] = 4'b0001;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    @(negedge clk);
    check("same_awready", awready[0], 1'b1);
    check("same_wready", wready[0], 1'b1);
    step();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    check("same_bvalid", bvalid[0], 1'b1);
    check("same_bresp", bresp[0], 1'b0);
    check("same_awready_resp", awready[0], 1'b0);
    step();
    bready[0] = 1'b0;
    check("same_bdone", bvalid[0], 1'b0);
    check("same_awready_back", awready[0], 1'b1);
    do_read(0, 2'd1, 8'hA5, 1'b0, "rd_reg1");

    // W three cycles ahead of AW
    wdata[0] = 8'h3C; wstrb[0] = 4'b0001; wvalid[0] = 1'b1; bready[0] = 1'b1;
    @(negedge clk);
    check("wfirst_wready", wready[0], 1'b1);
    step();
    wvalid[0] = 1'b0;
    check("wfirst_wready_c4", wready[0], 1'b0);
    check("wfirst_awready_c4", awready[0], 1'b1);
    check("wfirst_bvalid_c4", bvalid[0], 1'b0);
    repeat (2) begin
      step();
      check("wfirst_wready_hold", wready[0], 1'b0);
      check("wfirst_bvalid_hold", bvalid[0], 1'b0);
    end
    awaddr[0] = 2'd3; awvalid[0] = 1'b1;
    @(negedge clk);
    check("wfirst_wready_c6", wready[0], 1'b0);
    step();
    awvalid[0] = 1'b0;
    check("wfirst_bvalid_c7", bvalid[0], 1'b1);
    check("wfirst_bresp", bresp[0], 1'b0);
    step();
    bready[0] = 1'b0;
    check("wfirst_bdone", bvalid[0], 1'b0);
    do_read(0, 2'd3, 8'h3C, 1'b0, "rd_reg3");
    do_read(0, 2'd1, 8'hA5, 1'b0, "rd_reg1_kept");

    // Out-of-range access on the 3-register instance
    do_write(1, 2'd2, 8'h12, 4'b0001, 1'b0, "n3_wr2");
    do_write(1, 2'd3, 8'hFF, 4'b0001, 1'b1, "n3_wr3_slverr");
    do_read(1, 2'd3, 8'h00, 1'b1, "n3_rd3_slverr");
    do_read(1, 2'd2, 8'h12, 1'b0, "n3_rd2");
    do_read(1, 2'd0, 8'h00, 1'b0, "n3_rd0");

    // Strobe handling
    do_write(0, 2'd0, 8'h11, 4'b0001, 1'b0, "wr0_11");
    do_write(0, 2'd0, 8'h22, 4'b0000, 1'b0, "wr0_nostrb");
    do_read(0, 2'd0, 8'h11, 1'b0, "rd0_nostrb");
    do_write(0, 2'd0, 8'h99, 4'b1110, 1'b0, "wr0_highstrb");
    do_read(0, 2'd0, 8'h11, 1'b0, "rd0_highstrb");

    // Write commit and read of the same register on one edge
    awaddr[0] = 2'd0; wdata[0] = 8'h77; wstrb[0] = 4'b0001;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    araddr[0] = 2'd0; arvalid[0] = 1'b1; rready[0] = 1'b1;
    step();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    check("coll_rvalid", rvalid[0], 1'b1);
    check("coll_rdata_old", rdata[0], 8'h11);
    check("coll_bvalid", bvalid[0], 1'b1);
    step();
    bready[0] = 1'b0; rready[0] = 1'b0;
    check("coll_bdone", bvalid[0], 1'b0);
    check("coll_rdone", rvalid[0], 1'b0);
    do_read(0, 2'd0, 8'h77, 1'b0, "rd0_after_coll");

    // Reset while a write response is stalled
    awaddr[0] = 2'd2; wdata[0] = 8'h5A; wstrb[0] = 4'b0001;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
    step();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    check("stall_bvalid", bvalid[0], 1'b1);
    step();
    check("stall_bvalid_hold", bvalid[0], 1'b1);
    arst = 1'b1;
    step();
    check("midrst_bvalid", bvalid[0], 1'b0);
    check("midrst_awready", awready[0], 1'b0);
    check("midrst_arready", arready[0], 1'b0);
    arst = 1'b0;
    step();
    do_read(0, 2'd0, 8'h00, 1'b0, "postrst_rd0");
    do_read(0, 2'd1, 8'h00, 1'b0, "postrst_rd1");
    do_read(0, 2'd2, 8'h00, 1'b0, "postrst_rd2");
    do_read(0, 2'd3, 8'h00, 1'b0, "postrst_rd3");
    do_read(1, 2'd2, 8'h00, 1'b0, "postrst_n3_rd2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
